// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcodes, funct fields,
// ALU operations, bus size codes and the control FSM states.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;

  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {S_IF, S_EX, S_MEM} state_t;

  // OP and OP-IMM share funct3; SUB exists only in the register form.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                       input logic is_reg);
    case (f3)
      F3_ADD:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU; compare results also drive branch decisions.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [4:0]      shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  // Operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = a_s >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/cpu_top.sv
// Multi-cycle RV32I core: IF -> EX -> (MEM) -> IF, split instruction/data bus.
module cpu_top
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
)(
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] IAD,
  input  logic [XLEN-1:0] IDT,
  input  logic            ACKI_n,
  output logic [XLEN-1:0] DAD,
  output logic            MREQ,
  output logic            WRITE,
  output logic [1:0]      SIZE,
  inout  wire  [XLEN-1:0] DDT,
  input  logic            ACKD_n,
  input  logic [2:0]      OINT_n,
  output logic            IACK_n
);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, ir, dad, st_data;
  logic            mreq, wr;
  logic [1:0]      size;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic            alt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, pc_plus4;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  alu_op_t         alu_op;
  logic            br_taken, is_mem, wb_en;
  logic [XLEN-1:0] wb_val, pc_nx;
  logic            unused_irq;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign f3       = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign alt      = (ir[31:25] == F7_ALT);
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rs1_val  = rf[rs1];
  assign rs2_val  = rf[rs2];
  assign pc_plus4 = pc + 32'd4;

  function automatic logic [31:0] load_ext(input logic [2:0] fn, input logic [31:0] d);
    case (fn)
      F3_LB:   return {{24{d[7]}}, d[7:0]};
      F3_LH:   return {{16{d[15]}}, d[15:0]};
      F3_LBU:  return {24'b0, d[7:0]};
      F3_LHU:  return {16'b0, d[15:0]};
      F3_LW:   return d;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] fn, input logic [31:0] d);
    case (fn)
      F3_SB:   return {24'b0, d[7:0]};
      F3_SH:   return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [2:0] fn);
    case (fn[1:0])
      F3_SB[1:0]: return SZ_BYTE;
      F3_SH[1:0]: return SZ_HALF;
      default:    return SZ_WORD;
    endcase
  endfunction

  // ALU operand and operation selection from the decoded instruction
  always_comb begin
    alu_a  = rs1_val;
    alu_b  = rs2_val;
    alu_op = ALU_ADD;
    case (opcode)
      OP_JALR, OP_LOAD: alu_b = imm_i;
      OP_STORE:         alu_b = imm_s;
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = arith_op(f3, alt, 1'b0);
      end
      OP_OP:            alu_op = arith_op(f3, alt, 1'b1);
      OP_BRANCH: begin
        case (f3)
          F3_BEQ, F3_BNE: alu_op = ALU_SUB;
          F3_BLT, F3_BGE: alu_op = ALU_SLT;
          default:        alu_op = ALU_SLTU;
        endcase
      end
      default: ;
    endcase
  end

  cpu_alu #(.XLEN(XLEN)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // funct3[0] inverts the base condition (BNE/BGE/BGEU)
  assign br_taken = (f3[2] ? alu_y[0] : (alu_y == '0)) ^ f3[0];

  // Writeback value and next PC for the EX state
  always_comb begin
    wb_en  = 1'b0;
    wb_val = alu_y;
    pc_nx  = pc_plus4;
    is_mem = 1'b0;
    case (opcode)
      OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; wb_val = pc_plus4; pc_nx = pc + imm_j; end
      OP_JALR:  begin wb_en = 1'b1; wb_val = pc_plus4; pc_nx = alu_y & ~32'd1; end
      OP_BRANCH: if (br_taken) pc_nx = pc + imm_b;
      OP_LOAD, OP_STORE: is_mem = 1'b1;
      OP_IMM, OP_OP: wb_en = 1'b1;
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IF;
    else      state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IF:    if (!ACKI_n) state_nx = S_EX;
      S_EX:    state_nx = is_mem ? S_MEM : S_IF;
      S_MEM:   if (!ACKD_n) state_nx = S_IF;
      default: state_nx = S_IF;
    endcase
  end

  // Architectural state and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      dad     <= '0;
      mreq    <= 1'b0;
      wr      <= 1'b0;
      size    <= SZ_WORD;
      st_data <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IF: if (!ACKI_n) ir <= IDT;
        S_EX: begin
          if (is_mem) begin
            dad     <= alu_y;
            mreq    <= 1'b1;
            wr      <= (opcode == OP_STORE);
            size    <= size_of(f3);
            st_data <= store_lanes(f3, rs2_val);
          end else begin
            if (wb_en && rd != 5'd0) rf[rd] <= wb_val;
            pc <= pc_nx;
          end
        end
        S_MEM: if (!ACKD_n) begin
          if (!wr && rd != 5'd0) rf[rd] <= load_ext(f3, DDT);
          pc   <= pc_plus4;
          mreq <= 1'b0;
          wr   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign IAD        = pc;
  assign DAD        = dad;
  assign MREQ       = mreq;
  assign WRITE      = wr;
  assign SIZE       = size;
  assign DDT        = (mreq && wr) ? st_data : {XLEN{1'bz}};
  assign IACK_n     = 1'b1;
  assign unused_irq = ^OINT_n;

endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: feeds instructions one at a time on the
// instruction bus and checks data-bus transactions against a queue of
// expected accesses built from hand-computed results.
module tb_cpu_top;

  localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, OPL = 7'h03, OPU = 7'h37, OPJR = 7'h67;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] IAD, IDT, DAD;
  logic        ACKI_n = 1'b1, ACKD_n = 1'b1;
  logic        MREQ, WRITE, IACK_n;
  logic [1:0]  SIZE;
  logic [2:0]  OINT_n = 3'b111;
  wire  [31:0] DDT;
  logic [31:0] ddt_drv = 32'h0;
  logic        ddt_en  = 1'b0;

  bus_exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  assign DDT = ddt_en ? ddt_drv : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  cpu_top dut (
    .clk(clk), .rst(rst), .IAD(IAD), .IDT(IDT), .ACKI_n(ACKI_n),
    .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DDT(DDT),
    .ACKD_n(ACKD_n), .OINT_n(OINT_n), .IACK_n(IACK_n)
  );

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, OPU};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Present one instruction in IF, optionally withholding the ack first.
  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc, input int stall);
    @(negedge clk);
    chk("iad_if", IAD, pc);
    chk("mreq_if", 32'(MREQ), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("iad_stall", IAD, pc);
    end
    IDT    = instr;
    ACKI_n = 1'b0;
    @(posedge clk);
    #1 ACKI_n = 1'b1;
    IDT = 32'h0;
  endtask

  task automatic exec(input logic [31:0] instr, input logic [31:0] pc);
    fetch(instr, pc, 0);
    @(negedge clk);
    chk("iad_ex", IAD, pc);
    @(posedge clk);
    #1;
  endtask

  // Issue a load/store, then compare the bus against the oldest queued entry.
  task automatic mem_op(input logic [31:0] instr, input logic [31:0] pc, input logic wr,
                        input logic [1:0] sz, input logic [31:0] adr,
                        input logic [31:0] dat, input int hold);
    bus_exp_t e;
    int t;
    sb.push_back({wr, sz, adr, dat});
    fetch(instr, pc, 0);
    @(posedge clk);
    #1;
    t = 0;
    @(negedge clk);
    while (MREQ !== 1'b1 && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("mreq", 32'(MREQ), 32'd1);
    e = sb.pop_front();
    chk("write", 32'(WRITE), 32'(e.wr));
    chk("size", 32'(SIZE), 32'(e.sz));
    chk("dad", DAD, e.adr);
    if (!e.wr) begin
      ddt_drv = e.dat;
      ddt_en  = 1'b1;
      #1;
    end
    chk("ddt", DDT, e.dat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("mreq_hold", 32'(MREQ), 32'd1);
      chk("dad_hold", DAD, e.adr);
      chk("ddt_hold", DDT, e.dat);
      chk("iad_hold", IAD, pc);
    end
    ACKD_n = 1'b0;
    @(posedge clk);
    #1 ACKD_n = 1'b1;
    ddt_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for one edge; drive the data bus to prove the core releases it.
    ddt_drv = 32'hA5A5_5A5A;
    ddt_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_iad", IAD, 32'h0);
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_size", 32'(SIZE), 32'd0);
    chk("rst_dad", DAD, 32'h0);
    chk("rst_iack", 32'(IACK_n), 32'd1);
    chk("rst_ddt_free", DDT, 32'hA5A5_5A5A);
    rst    = 1'b1;
    ddt_en = 1'b0;

    exec(32'h0050_0093, 32'h00);                         // addi x1,x0,5
    exec(32'hffd0_8113, 32'h04);                         // addi x2,x1,-3
    exec(32'h0800_02b7, 32'h08);                         // lui x5,0x08000
    mem_op(32'h0022_a023, 32'h0C, 1'b1, 2'b00, 32'h0800_0000, 32'h2, 0);  // sw x2,0(x5)
    exec(enc_j(32'd8, 5'd1), 32'h10);                    // jal x1,+8
    mem_op(enc_s(32'd4, 5'd1, 5'd5, 3'd2), 32'h18, 1'b1, 2'b00, 32'h0800_0004, 32'h14, 0);
    fetch(enc_i(32'd7, 5'd0, 3'd0, 5'd3, OPI), 32'h1C, 2);  // addi x3,x0,7 (late ack)
    @(posedge clk);
    #1;
    exec(enc_b(-32'sd4, 5'd0, 5'd0, 3'd0), 32'h20);      // beq x0,x0,-4 taken
    mem_op(enc_s(32'd8, 5'd3, 5'd5, 3'd2), 32'h1C, 1'b1, 2'b00, 32'h0800_0008, 32'h7, 0);
    exec(enc_b(-32'sd4, 5'd0, 5'd3, 3'd0), 32'h20);      // beq x3,x0,-4 not taken
    exec(enc_i(32'h41, 5'd0, 3'd0, 5'd6, OPI), 32'h24);  // addi x6,x0,0x41
    exec(enc_i(32'd0, 5'd6, 3'd0, 5'd7, OPJR), 32'h28);  // jalr x7,0(x6) -> 0x40
    mem_op(enc_s(32'd12, 5'd7, 5'd5, 3'd2), 32'h40, 1'b1, 2'b00, 32'h0800_000C, 32'h2C, 0);
    exec(enc_u(20'hF0000, 5'd8), 32'h44);                // lui x8,0xF0000
    mem_op(enc_s(32'd0, 5'd6, 5'd8, 3'd0), 32'h48, 1'b1, 2'b10, 32'hF000_0000, 32'h41, 0);
    exec(enc_i(-32'sd8, 5'd0, 3'd0, 5'd10, OPI), 32'h4C);       // x10 = -8
    exec(enc_i(32'h401, 5'd10, 3'd5, 5'd11, OPI), 32'h50);      // srai x11,x10,1
    exec(enc_r(7'h00, 5'd1, 5'd10, 3'd2, 5'd12), 32'h54);       // slt x12,x10,x1
    exec(enc_r(7'h00, 5'd1, 5'd10, 3'd3, 5'd13), 32'h58);       // sltu x13,x10,x1
    exec(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd14), 32'h5C);        // sub x14,x1,x2
    mem_op(enc_s(32'd16, 5'd11, 5'd5, 3'd1), 32'h60, 1'b1, 2'b01, 32'h0800_0010, 32'h0000_FFFC, 0);
    mem_op(enc_s(32'd20, 5'd12, 5'd5, 3'd2), 32'h64, 1'b1, 2'b00, 32'h0800_0014, 32'h1, 0);
    mem_op(enc_s(32'd24, 5'd13, 5'd5, 3'd2), 32'h68, 1'b1, 2'b00, 32'h0800_0018, 32'h0, 3);
    mem_op(enc_s(32'd28, 5'd14, 5'd5, 3'd2), 32'h6C, 1'b1, 2'b00, 32'h0800_001C, 32'h12, 0);
    mem_op(enc_i(32'd0, 5'd5, 3'd0, 5'd15, OPL), 32'h70, 1'b0, 2'b10, 32'h0800_0000, 32'h80, 0);
    mem_op(enc_i(32'd1, 5'd5, 3'd4, 5'd16, OPL), 32'h74, 1'b0, 2'b10, 32'h0800_0001, 32'h80, 0);
    mem_op(enc_i(32'd2, 5'd5, 3'd1, 5'd17, OPL), 32'h78, 1'b0, 2'b01, 32'h0800_0002, 32'h8001, 0);
    mem_op(enc_i(32'd4, 5'd5, 3'd2, 5'd18, OPL), 32'h7C, 1'b0, 2'b00, 32'h0800_0004, 32'h1234_5678, 0);
    mem_op(enc_s(32'd32, 5'd15, 5'd5, 3'd2), 32'h80, 1'b1, 2'b00, 32'h0800_0020, 32'hFFFF_FF80, 0);
    mem_op(enc_s(32'd36, 5'd16, 5'd5, 3'd2), 32'h84, 1'b1, 2'b00, 32'h0800_0024, 32'h0000_0080, 0);
    mem_op(enc_s(32'd40, 5'd17, 5'd5, 3'd2), 32'h88, 1'b1, 2'b00, 32'h0800_0028, 32'hFFFF_8001, 0);
    mem_op(enc_s(32'd44, 5'd18, 5'd5, 3'd2), 32'h8C, 1'b1, 2'b00, 32'h0800_002C, 32'h1234_5678, 0);
    exec(enc_u(20'hFF000, 5'd19), 32'h90);               // lui x19,0xFF000
    mem_op(enc_s(32'd0, 5'd0, 5'd19, 3'd2), 32'h94, 1'b1, 2'b00, 32'hFF00_0000, 32'h0, 0);

    // Reset while a store waits in MEM must abandon it.
    fetch(enc_s(32'd0, 5'd1, 5'd5, 3'd2), 32'h98, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_pre_mreq", 32'(MREQ), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_iad", IAD, 32'h0);
    chk("abort_mreq", 32'(MREQ), 32'd0);
    chk("abort_write", 32'(WRITE), 32'd0);
    exec(32'h0050_0093, 32'h00);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
Name: cpu_top

Overview:
- Multi-cycle, non-pipelined RV32I integer core; the top-level processor of the design.
- Talks to a split instruction/data memory system through a simple bus:
  - Instruction bus: IAD out, IDT in, ACKI_n in.
  - Data bus: DAD, MREQ, WRITE and SIZE out, bidirectional DDT, ACKD_n in.
- Program exit and character output are memory-mapped stores handled by the memory side.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- XLEN, 32, datapath width (fixed; other values unsupported).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- IAD  out  32  instruction address (= PC register).
- IDT  in  32  instruction word for IAD, already in logical (little-endian value) order; no byte swap.
- ACKI_n  in  1  instruction ack, active-low.
- DAD  out  32  data address (registered).
- MREQ  out  1  data request (registered).
- WRITE  out  1  1 = store, 0 = load (registered).
- SIZE  out  2  access size: 00 word, 01 half, 10 byte (11 unused).
- DDT  inout  32  data bus. Driven by the core only when MREQ & WRITE, otherwise high-Z.
- OINT_n  in  3  interrupt requests, active-low; ignored.
- IACK_n  out  1  interrupt ack; constant 1.

Behaviour:
- Reset (rst == 0 at posedge):
  - PC = RESET_PC, state = IF.
  - MREQ = 0, WRITE = 0, SIZE = 00, DAD = 0, DDT = Z.
  - All x1..x31 = 0; x0 is hardwired to 0.
- States: IF -> EX -> (MEM) -> IF. All outputs come from registers or state only, so they are stable from the rising edge onward. The memory side samples them mid-cycle.
- IF state:
  - IAD = PC.
  - At posedge with ACKI_n == 0: IR <= IDT, go to EX.
  - At posedge with ACKI_n == 1: stay in IF.
- EX state:
  - Decode IR, read rs1/rs2, compute ALU result or effective address.
  - Non-memory instruction: at posedge write rd (unless rd = 0), update PC, go to IF.
  - Load/store: at posedge latch DAD = rs1 + imm, set MREQ = 1, set WRITE, set SIZE from funct3; latch store data; go to MEM.
- MEM state:
  - Outputs held.
  - Store data lanes: SW drives rs2; SH drives {16'b0, rs2[15:0]}; SB drives {24'b0, rs2[7:0]}.
  - Load data arrives in the low lanes: LW uses DDT; LH/LHU use DDT[15:0]; LB/LBU use DDT[7:0]. Extension follows funct3.
  - At posedge with ACKD_n == 0: write rd for loads, PC += 4, MREQ = 0, WRITE = 0, go to IF.
  - At posedge with ACKD_n == 1: stay in MEM, outputs unchanged.
- CPI: 2 for non-memory instructions, 3 for memory instructions (with 1-cycle acks).
- ISA: full RV32I (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP).
  - JALR target = (rs1 + imm) & ~1.
  - Shifts use the low 5 bits of the shift amount.
  - SLT/SLTU are signed/unsigned respectively.
- FENCE, ECALL, EBREAK, CSR and undefined opcodes execute as NOP (PC += 4).
- Misaligned addresses go onto DAD unchanged; the memory side does byte-lane selection.
- Memory-mapped addresses:
  - A store to 32'hFF00_0000 ends the program.
  - An SB to 32'hF000_0000 outputs the character DDT[7:0].
  - The core gives neither address special treatment.
- Reset asserted in any state aborts the instruction: the next cycle is IF at RESET_PC with MREQ = 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode / funct3 / funct7 constants;
  - ALU operation enum;
  - SIZE encodings (SZ_WORD, SZ_HALF, SZ_BYTE);
  - state enum (IF, EX, MEM).
- Sub-module cpu_alu: combinational ALU (add, sub, logic ops, shifts, compares), also used for branch decisions.
- The register file stays inline in cpu_top.

Test Plan:
- Reset: hold rst = 0 for one posedge -> IAD = 0, MREQ = 0, WRITE = 0, IACK_n = 1, DDT = Z.
- Arithmetic: 0x00500093 (addi x1,x0,5) then 0xffd08113 (addi x2,x1,-3) -> x2 = 2; IAD by cycle = 0, 0, 4, 4, 8.
- Store word: lui x5,0x08000 (0x080002b7), then sw x2,0(x5) (0x0022a023) -> MEM cycle shows MREQ = 1, WRITE = 1, SIZE = 00, DAD = 0x0800_0000, DDT = 0x0000_0002.
- Loads, with DDT = 0x0000_0080 returned:
  - lb -> rd = 0xFFFF_FF80;
  - lbu -> rd = 0x0000_0080;
  - with DDT = 0x0000_8001, lh -> rd = 0xFFFF_8001.
- Control flow:
  - jal x1,+8 at PC 0x10 -> x1 = 0x14, next IAD = 0x18;
  - beq taken with offset -4 at 0x20 -> next IAD = 0x1C;
  - jalr with odd target -> bit 0 cleared.
- Handshake and I/O:
  - sb of 0x41 to 0xF000_0000 -> SIZE = 10, DDT[7:0] = 0x41.
  - Hold ACKD_n = 1 for 3 cycles -> core stays in MEM with MREQ = 1 and outputs constant; completes on the first posedge with ACKD_n = 0.
  - sw to 0xFF00_0000 -> MREQ = 1, WRITE = 1.
